// File: rtl/alu_op_sequencer_pkg.sv
// Package alu_seq_pkg: shared types and constants for the ALU op sequencer.
//   state_t   : sequencer FSM states
//   OP_W      : ALU function-select width {f2,f1,f0}
//   OP_0..7   : the eight ALU function-select codes (all legal, passed through)
package alu_seq_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_0 = 3'b000;
    localparam logic [OP_W-1:0] OP_1 = 3'b001;
    localparam logic [OP_W-1:0] OP_2 = 3'b010;
    localparam logic [OP_W-1:0] OP_3 = 3'b011;
    localparam logic [OP_W-1:0] OP_4 = 3'b100;
    localparam logic [OP_W-1:0] OP_5 = 3'b101;
    localparam logic [OP_W-1:0] OP_6 = 3'b110;
    localparam logic [OP_W-1:0] OP_7 = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Interface alu_seq_if: request, ALU and response signals of the op sequencer.
//   req_valid/req_ready : per-requester handshake (ready is one-hot)
//   req_op/req_a/req_b  : packed per-requester op and operands, slice i at [i*W +: W]
//   alu_f/alu_a/alu_b   : registered select and operands to the shared ALU
//   alu_result          : combinational ALU output
//   rsp_valid/rsp_ready : response handshake; rsp_id/rsp_data carry the result
// Modports: slave = the sequencer, master = requesters + ALU + response sink.
interface alu_seq_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4
) ();
    localparam int OP_W = alu_seq_pkg::OP_W;
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [OP_W-1:0]           alu_f;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [DATA_W-1:0]         alu_result;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
        output req_ready, alu_f, alu_a, alu_b, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
        input  req_ready, alu_f, alu_a, alu_b, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/alu_op_sequencer_pick.sv
// Module alu_seq_pick: combinational winner select for the op sequencer.
//   valid : request vector
//   ptr   : round-robin search start (absent when ALU_SEQ_FIXED_PRIO_EN is defined)
//   grant : one-hot grant, zero when nothing is valid
//   idx   : index of the granted requester
//   any   : at least one request valid
// Macro ALU_SEQ_FIXED_PRIO_EN selects fixed priority (lowest index wins);
// default is round-robin starting at ptr and wrapping modulo NUM_REQ.
module alu_seq_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
`ifndef ALU_SEQ_FIXED_PRIO_EN
    input  logic [ID_W-1:0]    ptr,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

`ifndef ALU_SEQ_FIXED_PRIO_EN
    logic [ID_W-1:0] pos;
    logic            found;
`endif

    always_comb begin
        idx = '0;
        any = |valid;
`ifdef ALU_SEQ_FIXED_PRIO_EN
        // Descending scan so the lowest valid index is written last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid[ID_W'(k)]) idx = ID_W'(k);
        end
`else
        pos   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && valid[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
`endif
        grant = '0;
        if (any) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Module alu_op_sequencer: shares one combinational ALU among NUM_REQ requesters.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if.slave (request, ALU and response signals)
// Accepts one request, drives the ALU from registers for one settle cycle,
// captures the result and holds it tagged with the requester id until taken.
// Macro ALU_SEQ_FIXED_PRIO_EN: fixed priority arbitration, no RR pointer.
//
// state | meaning
// IDLE  | waiting for a request; grant offered combinationally
// ISSUE | operands on ALU, result settling; captured at end of cycle
// RESP  | rsp_valid high, result held until rsp_ready
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t             state;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_idx;
    logic               any_req;

`ifndef ALU_SEQ_FIXED_PRIO_EN
    logic [ID_W-1:0]    rr_ptr;
`endif

    alu_seq_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .valid (bus.req_valid),
`ifndef ALU_SEQ_FIXED_PRIO_EN
        .ptr   (rr_ptr),
`endif
        .grant (grant),
        .idx   (win_idx),
        .any   (any_req)
    );

    // rst_n gates the grant so nothing is offered while reset is held.
    assign bus.req_ready = (state == IDLE && rst_n) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.alu_f     <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
`ifndef ALU_SEQ_FIXED_PRIO_EN
            rr_ptr        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.alu_f  <= bus.req_op[win_idx*OP_W +: OP_W];
                        bus.alu_a  <= bus.req_a[win_idx*DATA_W +: DATA_W];
                        bus.alu_b  <= bus.req_b[win_idx*DATA_W +: DATA_W];
                        bus.rsp_id <= win_idx;
`ifndef ALU_SEQ_FIXED_PRIO_EN
                        rr_ptr     <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                                      : win_idx + ID_W'(1);
`endif
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.rsp_data  <= bus.alu_result;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
